// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: load-use / taken-branch / memory-wait sequencer for a 5-stage pipeline.
// Optional performance counters are built when PIPE_PERF_CNT_EN is defined.
`default_nettype none

module pipe_hazard_ctrl #(
  parameter int LOAD_STALL  = 1,
  parameter int FLUSH_EXTRA = 1,
  parameter int CNT_W       = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       id_rs_i,
  input  logic [4:0]       id_rt_i,
  input  logic             id_uses_rt_i,
  input  logic             ex_memread_i,
  input  logic [4:0]       ex_wbreg_i,
  input  logic             mem_branch_i,
  input  logic             mem_zero_i,
  input  logic             mem_req_i,
  input  logic             mem_ready_i,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             idex_flush_o,
  output logic             exmem_flush_o,
  output logic             pipe_hold_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_LDSTALL = 2'd1;
  localparam logic [1:0] ST_MEMWAIT = 2'd2;
  localparam logic [1:0] ST_FLUSH   = 2'd3;

  logic [1:0] state, state_nxt;
  logic [2:0] cnt, cnt_nxt;
  logic       lu_haz, br_tk, mwait;
  logic       act_hold, act_br, act_lu;
  logic       pc_wr, ifid_wr, ifid_fl, idex_fl, exmem_fl, hold;

  assign lu_haz = ex_memread_i && (ex_wbreg_i != 5'd0) &&
                  ((ex_wbreg_i == id_rs_i) || (id_uses_rt_i && (ex_wbreg_i == id_rt_i)));
  assign br_tk  = mem_branch_i & mem_zero_i;
  assign mwait  = mem_req_i & ~mem_ready_i;

  // Resolve the single winning event for this cycle; MEMWAIT ignores branches until ready.
  assign act_hold = (state == ST_MEMWAIT) ? ~mem_ready_i : mwait;
  assign act_br   = ~act_hold && br_tk && (state != ST_FLUSH);
  assign act_lu   = ~act_hold && ~act_br && lu_haz &&
                    ((state == ST_RUN) || (state == ST_MEMWAIT));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= ST_RUN;
      cnt   <= 3'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (act_hold) begin
      state_nxt = ST_MEMWAIT;
    end else if (act_br) begin
      cnt_nxt   = 3'(FLUSH_EXTRA);
      state_nxt = (FLUSH_EXTRA > 0) ? ST_FLUSH : ST_RUN;
    end else if (act_lu) begin
      cnt_nxt   = 3'(LOAD_STALL - 1);
      state_nxt = (LOAD_STALL > 1) ? ST_LDSTALL : ST_RUN;
    end else if ((state == ST_LDSTALL) || (state == ST_FLUSH)) begin
      cnt_nxt = cnt - 3'd1;
      if (cnt <= 3'd1)
        state_nxt = ST_RUN;
    end else begin
      state_nxt = ST_RUN;
    end
  end

  always_comb begin
    pc_wr    = 1'b1;
    ifid_wr  = 1'b1;
    ifid_fl  = 1'b0;
    idex_fl  = 1'b0;
    exmem_fl = 1'b0;
    hold     = 1'b0;
    if (act_hold) begin
      pc_wr   = 1'b0;
      ifid_wr = 1'b0;
      hold    = 1'b1;
    end else if (act_br) begin
      ifid_fl  = 1'b1;
      idex_fl  = 1'b1;
      exmem_fl = 1'b1;
    end else if (act_lu || (state == ST_LDSTALL)) begin
      pc_wr   = 1'b0;
      ifid_wr = 1'b0;
      idex_fl = 1'b1;
    end else if (state == ST_FLUSH) begin
      ifid_fl = 1'b1;
    end
  end

  // Reset freezes the whole pipeline, so every strobe is gated asynchronously.
  assign pc_write_o    = rst_i & pc_wr;
  assign ifid_write_o  = rst_i & ifid_wr;
  assign ifid_flush_o  = rst_i & ifid_fl;
  assign idex_flush_o  = rst_i & idex_fl;
  assign exmem_flush_o = rst_i & exmem_fl;
  assign pipe_hold_o   = rst_i & hold;
  assign state_o       = state;

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_wr && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + 1'b1;
      if (act_br && (flush_cnt != {CNT_W{1'b1}}))
        flush_cnt <= flush_cnt + 1'b1;
    end
  end

  assign stall_cnt_o = stall_cnt;
  assign flush_cnt_o = flush_cnt;
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: per-cycle strobe/state vectors queued with stimulus.
`default_nettype none

module tb_pipe_hazard_ctrl;

`ifdef PIPE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  id_rs = '0, id_rt = '0, ex_wbreg = '0;
  logic        id_uses_rt = 0, ex_memread = 0, mem_branch = 0, mem_zero = 0;
  logic        mem_req = 0, mem_ready = 1;
  logic        pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush, pipe_hold;
  logic [1:0]  state;
  logic [15:0] stall_cnt, flush_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int stall_m  = 0;
  int flush_m  = 0;

  logic [20:0] stim_q[$];
  logic [7:0]  exp_q[$];

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.LOAD_STALL(1), .FLUSH_EXTRA(1), .CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst_n),
    .id_rs_i(id_rs), .id_rt_i(id_rt), .id_uses_rt_i(id_uses_rt),
    .ex_memread_i(ex_memread), .ex_wbreg_i(ex_wbreg),
    .mem_branch_i(mem_branch), .mem_zero_i(mem_zero),
    .mem_req_i(mem_req), .mem_ready_i(mem_ready),
    .pc_write_o(pc_write), .ifid_write_o(ifid_write), .ifid_flush_o(ifid_flush),
    .idex_flush_o(idex_flush), .exmem_flush_o(exmem_flush), .pipe_hold_o(pipe_hold),
    .state_o(state), .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
  );

  // {memread, wbreg, rs, rt, uses_rt, branch, zero, req, ready}
  function automatic logic [20:0] mk(input logic rd, input logic [4:0] wb, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic urt, input logic br,
                                     input logic zr, input logic rq, input logic rdy);
    return {rd, wb, rs, rt, urt, br, zr, rq, rdy};
  endfunction

  task automatic apply(input logic [20:0] v);
    {ex_memread, ex_wbreg, id_rs, id_rt, id_uses_rt, mem_branch, mem_zero, mem_req, mem_ready} = v;
  endtask

  // {state, pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush, pipe_hold}
  function automatic logic [7:0] obs();
    return {state, pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush, pipe_hold};
  endfunction

  task automatic test_reset();
    logic [7:0] e, g;
    int c = 0;
    repeat (2) begin stim_q.push_back(mk(0,0,0,0,0,0,0,0,1)); exp_q.push_back(8'h00); end
    while (stim_q.size() != 0) begin
      apply(stim_q.pop_front());
      @(negedge clk);
      e = exp_q.pop_front(); g = obs(); n_checks++;
      if (g !== e) begin n_fail++; $display("FAIL reset_hold c%0d: got %h expected %h", c, g, e); end
      @(posedge clk); #1;
      c++;
    end
    n_checks++;
    if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
      n_fail++; $display("FAIL reset_cnt: got %0d/%0d expected 0/0", stall_cnt, flush_cnt);
    end
    rst_n = 1'b1;
    repeat (3) begin stim_q.push_back(mk(0,0,0,0,0,0,0,0,1)); exp_q.push_back(8'h30); end
    while (stim_q.size() != 0) begin
      apply(stim_q.pop_front());
      @(negedge clk);
      e = exp_q.pop_front(); g = obs(); n_checks++;
      if (g !== e) begin n_fail++; $display("FAIL reset_idle c%0d: got %h expected %h", c, g, e); end
      @(posedge clk); #1;
      if (rst_n && PERF) begin stall_m += int'(!e[5]); flush_m += int'(e[1]); end
      c++;
    end
  endtask

  task automatic test_load_use();
    logic [7:0] e, g;
    int c = 0;
    stim_q.push_back(mk(1,5,5,0,0,0,0,0,1)); exp_q.push_back(8'h04);
    stim_q.push_back(mk(0,0,0,0,0,0,0,0,1)); exp_q.push_back(8'h30);
    stim_q.push_back(mk(1,0,0,0,0,0,0,0,1)); exp_q.push_back(8'h30);
    stim_q.push_back(mk(1,7,1,7,1,0,0,0,1)); exp_q.push_back(8'h04);
    stim_q.push_back(mk(1,7,1,7,0,0,0,0,1)); exp_q.push_back(8'h30);
    stim_q.push_back(mk(1,9,9,0,0,0,0,0,1)); exp_q.push_back(8'h04);
    stim_q.push_back(mk(1,9,9,0,0,0,0,0,1)); exp_q.push_back(8'h04);
    stim_q.push_back(mk(0,0,0,0,0,0,0,0,1)); exp_q.push_back(8'h30);
    while (stim_q.size() != 0) begin
      apply(stim_q.pop_front());
      @(negedge clk);
      e = exp_q.pop_front(); g = obs(); n_checks++;
      if (g !== e) begin n_fail++; $display("FAIL load_use c%0d: got %h expected %h", c, g, e); end
      @(posedge clk); #1;
      if (rst_n && PERF) begin stall_m += int'(!e[5]); flush_m += int'(e[1]); end
      c++;
    end
    n_checks++;
    if (stall_cnt !== 16'(stall_m)) begin
      n_fail++; $display("FAIL load_use_cnt: got %0d expected %0d", stall_cnt, stall_m);
    end
  endtask

  task automatic test_branch();
    logic [7:0] e, g;
    int c = 0;
    stim_q.push_back(mk(0,0,0,0,0,1,1,0,1)); exp_q.push_back(8'h3E);
    stim_q.push_back(mk(0,0,0,0,0,0,0,0,1)); exp_q.push_back(8'hF8);
    stim_q.push_back(mk(0,0,0,0,0,0,0,0,1)); exp_q.push_back(8'h30);
    stim_q.push_back(mk(0,0,0,0,0,1,0,0,1)); exp_q.push_back(8'h30);
    while (stim_q.size() != 0) begin
      apply(stim_q.pop_front());
      @(negedge clk);
      e = exp_q.pop_front(); g = obs(); n_checks++;
      if (g !== e) begin n_fail++; $display("FAIL branch c%0d: got %h expected %h", c, g, e); end
      @(posedge clk); #1;
      if (rst_n && PERF) begin stall_m += int'(!e[5]); flush_m += int'(e[1]); end
      c++;
    end
    n_checks++;
    if (flush_cnt !== 16'(flush_m)) begin
      n_fail++; $display("FAIL branch_cnt: got %0d expected %0d", flush_cnt, flush_m);
    end
  endtask

  task automatic test_memwait();
    logic [7:0] e, g;
    int c = 0;
    int s0 = stall_m;
    stim_q.push_back(mk(0,0,0,0,0,0,0,1,0)); exp_q.push_back(8'h01);
    stim_q.push_back(mk(0,0,0,0,0,0,0,1,0)); exp_q.push_back(8'h81);
    stim_q.push_back(mk(0,0,0,0,0,1,1,1,0)); exp_q.push_back(8'h81);
    stim_q.push_back(mk(0,0,0,0,0,0,0,1,0)); exp_q.push_back(8'h81);
    stim_q.push_back(mk(0,0,0,0,0,0,0,1,1)); exp_q.push_back(8'hB0);
    stim_q.push_back(mk(0,0,0,0,0,0,0,0,1)); exp_q.push_back(8'h30);
    while (stim_q.size() != 0) begin
      apply(stim_q.pop_front());
      @(negedge clk);
      e = exp_q.pop_front(); g = obs(); n_checks++;
      if (g !== e) begin n_fail++; $display("FAIL memwait c%0d: got %h expected %h", c, g, e); end
      @(posedge clk); #1;
      if (rst_n && PERF) begin stall_m += int'(!e[5]); flush_m += int'(e[1]); end
      c++;
    end
    n_checks++;
    if (stall_cnt !== 16'(stall_m) || (PERF && (stall_m - s0) != 4)) begin
      n_fail++; $display("FAIL memwait_cnt: got %0d expected %0d", stall_cnt, s0 + (PERF ? 4 : 0));
    end
  endtask

  task automatic test_release_events();
    logic [7:0] e, g;
    int c = 0;
    stim_q.push_back(mk(0,0,0,0,0,0,0,1,0)); exp_q.push_back(8'h01);
    stim_q.push_back(mk(1,3,3,0,0,1,1,1,1)); exp_q.push_back(8'hBE);
    stim_q.push_back(mk(0,0,0,0,0,0,0,0,1)); exp_q.push_back(8'hF8);
    stim_q.push_back(mk(0,0,0,0,0,0,0,1,0)); exp_q.push_back(8'h01);
    stim_q.push_back(mk(1,3,3,0,0,0,0,1,1)); exp_q.push_back(8'h84);
    stim_q.push_back(mk(0,0,0,0,0,1,1,0,1)); exp_q.push_back(8'h3E);
    stim_q.push_back(mk(0,0,0,0,0,0,0,1,0)); exp_q.push_back(8'hC1);
    stim_q.push_back(mk(0,0,0,0,0,0,0,1,1)); exp_q.push_back(8'hB0);
    stim_q.push_back(mk(1,4,4,0,0,1,1,0,1)); exp_q.push_back(8'h3E);
    stim_q.push_back(mk(0,0,0,0,0,0,0,0,1)); exp_q.push_back(8'hF8);
    stim_q.push_back(mk(0,0,0,0,0,0,0,0,1)); exp_q.push_back(8'h30);
    while (stim_q.size() != 0) begin
      apply(stim_q.pop_front());
      @(negedge clk);
      e = exp_q.pop_front(); g = obs(); n_checks++;
      if (g !== e) begin n_fail++; $display("FAIL release_events c%0d: got %h expected %h", c, g, e); end
      @(posedge clk); #1;
      if (rst_n && PERF) begin stall_m += int'(!e[5]); flush_m += int'(e[1]); end
      c++;
    end
    n_checks++;
    if (stall_cnt !== 16'(stall_m) || flush_cnt !== 16'(flush_m)) begin
      n_fail++; $display("FAIL release_cnt: got %0d/%0d expected %0d/%0d",
                         stall_cnt, flush_cnt, stall_m, flush_m);
    end
  endtask

  task automatic test_reset_midop();
    logic [7:0] e, g;
    int c = 0;
    stim_q.push_back(mk(0,0,0,0,0,0,0,1,0)); exp_q.push_back(8'h01);
    stim_q.push_back(mk(0,0,0,0,0,0,0,1,0)); exp_q.push_back(8'h81);
    while (stim_q.size() != 0) begin
      apply(stim_q.pop_front());
      @(negedge clk);
      e = exp_q.pop_front(); g = obs(); n_checks++;
      if (g !== e) begin n_fail++; $display("FAIL midop_pre c%0d: got %h expected %h", c, g, e); end
      @(posedge clk); #1;
      if (rst_n && PERF) begin stall_m += int'(!e[5]); flush_m += int'(e[1]); end
      c++;
    end
    #2;
    exp_q.push_back(8'h81);
    e = exp_q.pop_front(); g = obs(); n_checks++;
    if (g !== e) begin n_fail++; $display("FAIL midop_hold: got %h expected %h", g, e); end
    rst_n = 1'b0;
    exp_q.push_back(8'h00);
    #1;
    e = exp_q.pop_front(); g = obs(); n_checks++;
    if (g !== e) begin n_fail++; $display("FAIL midop_async: got %h expected %h", g, e); end
    stall_m = 0; flush_m = 0;
    n_checks++;
    if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
      n_fail++; $display("FAIL midop_cnt: got %0d/%0d expected 0/0", stall_cnt, flush_cnt);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    stim_q.push_back(mk(0,0,0,0,0,0,0,0,1)); exp_q.push_back(8'h30);
    stim_q.push_back(mk(1,6,6,0,0,0,0,0,1)); exp_q.push_back(8'h04);
    while (stim_q.size() != 0) begin
      apply(stim_q.pop_front());
      @(negedge clk);
      e = exp_q.pop_front(); g = obs(); n_checks++;
      if (g !== e) begin n_fail++; $display("FAIL midop_post c%0d: got %h expected %h", c, g, e); end
      @(posedge clk); #1;
      if (rst_n && PERF) begin stall_m += int'(!e[5]); flush_m += int'(e[1]); end
      c++;
    end
    n_checks++;
    if (stall_cnt !== 16'(stall_m) || flush_cnt !== 16'(flush_m)) begin
      n_fail++; $display("FAIL midop_post_cnt: got %0d/%0d expected %0d/%0d",
                         stall_cnt, flush_cnt, stall_m, flush_m);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_load_use();
    test_branch();
    test_memwait();
    test_release_events();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central hazard/sequencing controller for the 5-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC.
- Detects load-use hazards, taken branches resolved in MEM, and multi-cycle data-memory waits.
- Drives per-stage write-enable, flush and hold strobes from a small FSM with stall/flush counters.

Parameters:
- LOAD_STALL, 1, bubble cycles inserted per load-use hazard (1..7).
- FLUSH_EXTRA, 1, extra IF/ID flush cycles after a taken branch (0..7).
- CNT_W, 16, width of the performance counters.

Ports:
- clk_i  in  1  system clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- id_rs_i  in  5  rs field of the instruction in ID.
- id_rt_i  in  5  rt field of the instruction in ID.
- id_uses_rt_i  in  1  ID instruction reads rt.
- ex_memread_i  in  1  ID/EX memory-read control bit.
- ex_wbreg_i  in  5  ID/EX destination register.
- mem_branch_i  in  1  EX/MEM branch control bit.
- mem_zero_i  in  1  EX/MEM zero flag.
- mem_req_i  in  1  EX/MEM holds a load or store.
- mem_ready_i  in  1  data memory completes the access this cycle.
- pc_write_o  out  1  PC load enable.
- ifid_write_o  out  1  IF/ID load enable.
- ifid_flush_o  out  1  IF/ID clear to NOP.
- idex_flush_o  out  1  ID/EX clear to bubble.
- exmem_flush_o  out  1  EX/MEM clear to bubble.
- pipe_hold_o  out  1  freeze all pipeline registers and the PC.
- state_o  out  2  current FSM state.
- stall_cnt_o  out  CNT_W  stall cycles counted.
- flush_cnt_o  out  CNT_W  taken-branch flushes counted.

Behaviour:
- Definitions: lu_haz = ex_memread_i & (ex_wbreg_i!=0) & (ex_wbreg_i==id_rs_i | (id_uses_rt_i & ex_wbreg_i==id_rt_i)). br_tk = mem_branch_i & mem_zero_i. mwait = mem_req_i & ~mem_ready_i.
- States: RUN=0, LDSTALL=1, MEMWAIT=2, FLUSH=3. Strobe outputs are combinational from state and inputs. state_o and the counters are registered.
- While rst_i=0: state=RUN, counters=0. All strobes are forced to 0, including pc_write_o and ifid_write_o, so the pipeline is frozen. Reset mid-operation aborts any state immediately.
- Default (no event): pc_write_o=1, ifid_write_o=1, all flushes 0, pipe_hold_o=0.
- RUN priority is mwait > br_tk > lu_haz.
- RUN, mwait: pipe_hold_o=1, pc_write_o=0, ifid_write_o=0. Next state MEMWAIT.
- RUN, br_tk: ifid_flush_o=idex_flush_o=exmem_flush_o=1, pc_write_o=1 (branch target). Next state is FLUSH if FLUSH_EXTRA>0, else RUN. Flush counter is loaded with FLUSH_EXTRA.
- RUN, lu_haz: pc_write_o=0, ifid_write_o=0, idex_flush_o=1. Next state is LDSTALL if LOAD_STALL>1, else RUN. Stall counter is loaded with LOAD_STALL-1.
- LDSTALL: same strobes as the RUN load-use case; counter decrements each cycle. At count 1, return to RUN.
- LDSTALL, br_tk arrives: the branch overrides; act exactly as RUN with br_tk.
- MEMWAIT: hold strobes stay asserted while mem_ready_i=0.
- MEMWAIT, mem_ready_i=1: hold drops in the same cycle, and the cycle is evaluated as RUN excluding the mwait term (br_tk, then lu_haz). br_tk is ignored while holding.
- FLUSH: ifid_flush_o=1, pc_write_o=1, ifid_write_o=1; counter decrements each cycle. At count 1, return to RUN.
- FLUSH, mwait: goes to MEMWAIT, and the remaining flush cycles are discarded.
- A flush strobe always wins over a write-enable on the same register.

Optional Feature:
- Macro: PIPE_PERF_CNT_EN.
- Defined: stall_cnt_o increments on every cycle with pc_write_o=0 (out of reset). flush_cnt_o increments once per accepted br_tk. Both saturate at all-ones and clear on reset.
- Undefined: both outputs are tied to 0 and no counter flops are built.

Test Plan:
- Reset release, no hazards: after rst_i rises, pc_write_o=ifid_write_o=1 every cycle, state_o=0, no flush.
- Load-use: ex_memread_i=1, ex_wbreg_i=5, id_rs_i=5 for 1 cycle → exactly 1 cycle with pc_write_o=0, idex_flush_o=1. Repeat with ex_wbreg_i=0 → no stall.
- Taken branch: mem_branch_i=1, mem_zero_i=1 → cycle 0 has all three flushes=1. Cycle 1 has ifid_flush_o=1 only (state 3). Cycle 2 is back in RUN. flush_cnt_o=1 with the macro defined.
- Memory wait: mem_req_i=1, mem_ready_i=0 for 4 cycles, then 1 → pipe_hold_o=1 for exactly 4 cycles, state_o=2, stall_cnt_o=4.
- Simultaneous br_tk and lu_haz in RUN → flushes asserted, pc_write_o=1, no stall counted.
- Assert rst_i=0 during MEMWAIT → all strobes go to 0 asynchronously. After release, state_o=0 and the counters read 0.
